// File: rtl/mppt_pkg.sv
// Shared encodings for the MPPT PWM drive: MPPT FSM state of interest,
// step-request flags and drive operating modes.
package mppt_pkg;

  localparam logic [2:0] ST_APPLY = 3'd4;

  typedef enum logic [1:0] {
    FLAG_HOLD  = 2'b00,
    FLAG_INC   = 2'b01,
    FLAG_DEC   = 2'b10,
    FLAG_HOLD2 = 2'b11
  } flag_e;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_SOFT  = 2'b01,
    MODE_TRACK = 2'b10
  } mode_e;

endpackage

// File: rtl/mppt_pwm_counter.sv
// Free-running PWM counter with wrap pulse, period-aligned duty shadow and
// registered compare output.
module mppt_pwm_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] duty_req,
  output logic             pwm,
  output logic             period_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic             tick_q, tick_d;
  logic             pwm_q, pwm_d;
  logic             wrap;

  assign wrap = run && (cnt_q == '1);

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    cnt_d      = cnt_q;
    duty_act_d = duty_act_q;
    tick_d     = 1'b0;
    pwm_d      = 1'b0;
    if (clear) begin
      cnt_d      = '0;
      duty_act_d = '0;
    end else if (run) begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = wrap;
      // The shadow only changes at the period boundary so a period never mixes duties.
      if (wrap) duty_act_d = duty_req;
      pwm_d  = (cnt_q < duty_act_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      duty_act_q <= '0;
      tick_q     <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      duty_act_q <= duty_act_d;
      tick_q     <= tick_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm         = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: rtl/mppt_pwm_drive.sv
// MPPT gate drive: soft-start ramp, then clamped duty steps requested by the
// MPPT FSM once per visit to its apply state.
module mppt_pwm_drive
  import mppt_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DUTY_MIN  = 16,
  parameter int unsigned DUTY_MAX  = 240,
  parameter int unsigned DUTY_INIT = 64,
  parameter int unsigned STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       state,
  input  logic [1:0]       flag,
  output logic             pwm,
  output logic [CNT_W-1:0] duty,
  output logic             period_tick,
  output logic [1:0]       sat,
  output logic [1:0]       mode
);

  localparam logic [CNT_W-1:0] MIN_N  = CNT_W'(DUTY_MIN);
  localparam logic [CNT_W-1:0] MAX_N  = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0] INIT_N = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W:0]   MIN_W  = (CNT_W+1)'(DUTY_MIN);
  localparam logic [CNT_W:0]   MAX_W  = (CNT_W+1)'(DUTY_MAX);
  localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(STEP);

  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] duty_req_q, duty_req_d;
  logic [2:0]       state_q;
  logic             step;
  logic             tick;
  logic [CNT_W:0]   duty_ext, duty_inc, duty_dec;

  // One extra bit keeps over/underflow visible to the clamp compare.
  assign duty_ext = {1'b0, duty_req_q};
  assign duty_inc = duty_ext + STEP_W;
  assign duty_dec = duty_ext - STEP_W;
  assign step     = (mode_q == MODE_TRACK) && (state == ST_APPLY) && (state_q != ST_APPLY);

  always_comb begin
    mode_d     = mode_q;
    duty_req_d = duty_req_q;
    if (!en) begin
      mode_d     = MODE_IDLE;
      duty_req_d = MIN_N;
    end else begin
      case (mode_q)
        MODE_IDLE: begin
          mode_d     = MODE_SOFT;
          duty_req_d = MIN_N;
        end
        MODE_SOFT: begin
          if (duty_req_q == INIT_N) mode_d = MODE_TRACK;
          else if (tick)            duty_req_d = duty_req_q + CNT_W'(1);
        end
        MODE_TRACK: begin
          if (step) begin
            case (flag)
              FLAG_INC: duty_req_d = (duty_inc > MAX_W) ? MAX_N : duty_inc[CNT_W-1:0];
              FLAG_DEC: duty_req_d = (duty_dec[CNT_W] || duty_dec < MIN_W) ? MIN_N
                                                                         : duty_dec[CNT_W-1:0];
              default:  duty_req_d = duty_req_q;
            endcase
          end
        end
        default: mode_d = MODE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_IDLE;
      duty_req_q <= MIN_N;
      state_q    <= 3'd0;
    end else begin
      mode_q     <= mode_d;
      duty_req_q <= duty_req_d;
      state_q    <= state;
    end
  end

  // Clearing on the next-mode decision makes an en drop take effect at the very next edge.
  mppt_pwm_counter #(.CNT_W(CNT_W)) u_counter (
    .clk         (clk),
    .rst         (rst),
    .run         (mode_q != MODE_IDLE),
    .clear       (mode_d == MODE_IDLE),
    .duty_req    (duty_req_q),
    .pwm         (pwm),
    .period_tick (tick)
  );

  assign period_tick = tick;
  assign duty        = duty_req_q;
  assign mode        = mode_q;
  assign sat         = {duty_req_q == MAX_N, duty_req_q == MIN_N};

endmodule

// File: tb/tb_mppt_pwm_drive.sv
// Directed bench for mppt_pwm_drive: instance A uses default parameters,
// instance B starts tracking at 62 so the 238/18 clamp cases are reachable.
module tb_mppt_pwm_drive;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [2:0] state;
  logic [1:0] flag;

  logic       pwm_a, tick_a, pwm_b, tick_b;
  logic [7:0] duty_a, duty_b;
  logic [1:0] sat_a, mode_a, sat_b, mode_b;

  int n_checks = 0;
  int n_fail   = 0;
  int hi;

  always #5 clk = ~clk;

  mppt_pwm_drive u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .state(state), .flag(flag),
    .pwm(pwm_a), .duty(duty_a), .period_tick(tick_a), .sat(sat_a), .mode(mode_a)
  );

  mppt_pwm_drive #(.DUTY_INIT(62)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .state(state), .flag(flag),
    .pwm(pwm_b), .duty(duty_b), .period_tick(tick_b), .sat(sat_b), .mode(mode_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] f_duty(input bit b); return b ? duty_b : duty_a; endfunction
  function automatic logic       f_tick(input bit b); return b ? tick_b : tick_a; endfunction
  function automatic logic       f_pwm (input bit b); return b ? pwm_b  : pwm_a;  endfunction
  function automatic logic [1:0] f_mode(input bit b); return b ? mode_b : mode_a; endfunction
  function automatic logic [1:0] f_sat (input bit b); return b ? sat_b  : sat_a;  endfunction

  // One step request: state rises to ST_APPLY for a single cycle.
  task automatic do_step(input logic [1:0] f);
    @(negedge clk); state = 3'd4; flag = f;
    @(negedge clk); state = 3'd0; flag = 2'b00;
  endtask

  task automatic count_period(input bit b, output int n_hi);
    n_hi = 0;
    repeat (256) begin
      @(negedge clk);
      n_hi += int'(f_pwm(b));
    end
  endtask

  task automatic wait_tick(input bit b, input string tag);
    int n = 0;
    while (!f_tick(b) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, f_tick(b), 1);
  endtask

  task automatic wait_pwm_high(input bit b, input string tag);
    int n = 0;
    while (!f_pwm(b) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(tag, f_pwm(b), 1);
  endtask

  // Ramp through SOFT while wiggling flag/state, which must have no effect.
  task automatic soft_start(input bit b, input int exp_ticks, input int init);
    int ticks = 0;
    int n = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (f_tick(b)) ticks++;
      if (f_duty(b) == init[7:0]) break;
      flag  = n[1:0];
      state = n[2] ? 3'd4 : 3'd0;
    end
    state = 3'd0;
    flag  = 2'b00;
    check("soft_ticks", ticks, exp_ticks);
    check("soft_duty", f_duty(b), init);
    check("soft_mode_still_soft", f_mode(b), 2'b01);
    @(negedge clk);
    check("soft_to_track", f_mode(b), 2'b10);
  endtask

  initial begin
    rst = 1'b0; en_a = 1'b0; en_b = 1'b0; state = 3'd0; flag = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_mode_a", mode_a, 2'b00);
    check("rst_duty_a", duty_a, 16);
    check("rst_pwm_a", pwm_a, 0);
    check("rst_tick_a", tick_a, 0);
    check("rst_sat_a", sat_a, 2'b01);
    check("rst_duty_b", duty_b, 16);

    rst = 1'b1; en_a = 1'b1;
    @(negedge clk);
    check("entry_mode", mode_a, 2'b01);
    check("entry_duty", duty_a, 16);
    check("b_stays_idle", mode_b, 2'b00);
    soft_start(1'b0, 48, 64);

    // First step, then ST_APPLY held: exactly one step.
    state = 3'd4; flag = 2'b01;
    @(negedge clk);
    check("step_next_cycle", duty_a, 68);
    check("sat_mid", sat_a, 2'b00);
    repeat (19) @(negedge clk);
    check("hold_one_step", duty_a, 68);
    state = 3'd0; flag = 2'b00;

    wait_tick(1'b0, "tick_after_step");
    count_period(1'b0, hi);
    check("pwm_hi_68", hi, 68);
    check("tick_period_256", tick_a, 1);

    // Step on the wrap edge: old duty this period, new duty next period.
    repeat (255) @(negedge clk);
    state = 3'd4; flag = 2'b01;
    @(negedge clk);
    state = 3'd0; flag = 2'b00;
    check("wrap_tick", tick_a, 1);
    check("wrap_duty", duty_a, 72);
    count_period(1'b0, hi);
    check("wrap_old_period", hi, 68);
    count_period(1'b0, hi);
    check("wrap_new_period", hi, 72);

    repeat (42) do_step(2'b01);
    check("up_to_240", duty_a, 240);
    check("sat_max", sat_a, 2'b10);
    do_step(2'b01);
    check("clamp_max", duty_a, 240);
    repeat (20) do_step(2'b10);
    check("down_to_160", duty_a, 160);
    do_step(2'b11);
    check("flag11_hold", duty_a, 160);
    do_step(2'b00);
    check("flag00_hold", duty_a, 160);
    repeat (36) do_step(2'b10);
    check("down_to_16", duty_a, 16);
    check("sat_min", sat_a, 2'b01);
    do_step(2'b10);
    check("clamp_min", duty_a, 16);

    repeat (6) do_step(2'b01);
    check("up_to_40", duty_a, 40);
    wait_pwm_high(1'b0, "pwm_high_before_drop");
    en_a = 1'b0;
    @(negedge clk);
    check("drop_pwm", pwm_a, 0);
    check("drop_duty", duty_a, 16);
    check("drop_mode", mode_a, 2'b00);
    check("drop_tick", tick_a, 0);

    en_b = 1'b1;
    @(negedge clk);
    check("b_entry_mode", mode_b, 2'b01);
    soft_start(1'b1, 46, 62);
    repeat (44) do_step(2'b01);
    check("b_238", duty_b, 238);
    check("b_sat_238", sat_b, 2'b00);
    do_step(2'b01);
    check("b_clamp_240", duty_b, 240);
    check("b_sat_max", sat_b, 2'b10);

    wait_pwm_high(1'b1, "b_pwm_high_before_rst");
    #3 rst = 1'b0;
    #1;
    check("rst_async_pwm", pwm_b, 0);
    check("rst_async_duty", duty_b, 16);
    check("rst_async_mode", mode_b, 2'b00);
    check("rst_async_sat", sat_b, 2'b01);
    @(negedge clk);
    rst = 1'b1;

    soft_start(1'b1, 46, 62);
    repeat (11) do_step(2'b10);
    check("b_18", duty_b, 18);
    do_step(2'b10);
    check("b_clamp_16", duty_b, 16);
    check("b_sat_min", sat_b, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
